// File: rtl/game_pkg.sv
// Shared definitions for the game-tick scheduling blocks: FSM encoding, default widths, frame timer period.
// Combinational helpers only; no state.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int unsigned DEF_TICK_DIV = 1;
    localparam int unsigned DEF_CNT_W    = 16;
    localparam int unsigned DEF_OVR_W    = 8;
    localparam int unsigned DIV_W        = 8;
    localparam int unsigned TICK_PERIOD  = 5000000;

    function automatic logic busy_of(input state_t s, input logic pending);
        return (s != ST_IDLE) || pending;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Divides a tick pulse stream by DIV; o_qt is combinational on every DIV-th unheld tick.
// Zero latency on o_qt; i_hold freezes the count and discards ticks (no backpressure).
module tick_divider
    import game_pkg::*;
#(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_tick,
    input  logic i_hold,
    output logic o_qt
);

    logic [DIV_W-1:0] r_div;
    logic             w_wrap;
    logic             w_take;

    assign w_wrap = (r_div == DIV_W'(DIV - 1));
    assign w_take = i_tick && !i_hold;
    assign o_qt   = w_take && w_wrap;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_div <= '0;
        end else if (w_take) begin
            r_div <= w_wrap ? '0 : r_div + DIV_W'(1);
        end
    end

endmodule

// File: rtl/game_tick_sched.sv
// Turns divided frame ticks into a req/ack step handshake with a one-deep pending slot and overrun count.
// Tick-to-req latency 1 cycle; ack holds off new requests, extra ticks are buffered once then counted as overruns.
// Optional GAME_TICK_SINGLE_STEP_EN adds step_i for single-stepping while paused.
module game_tick_sched
    import game_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEF_TICK_DIV,
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned OVR_W    = DEF_OVR_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             tick_i,
    input  logic             pause_i,
`ifdef GAME_TICK_SINGLE_STEP_EN
    input  logic             step_i,
`endif
    output logic             step_req_o,
    input  logic             step_ack_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] step_cnt_o,
    output logic [OVR_W-1:0] overrun_cnt_o
);

    state_t           r_state;
    logic             r_pending;
    logic             r_req;
    logic             r_busy;
    logic [CNT_W-1:0] r_step_cnt;
    logic [OVR_W-1:0] r_ovr_cnt;

    state_t           w_state_nxt;
    logic             w_pending_nxt;
    logic             w_step_inc;
    logic             w_ovr_inc;
    logic             w_div_qt;
    logic             w_qt;

    tick_divider #(
        .DIV (TICK_DIV)
    ) u_div (
        .clk    (clk),
        .rstn   (rstn),
        .i_tick (tick_i),
        .i_hold (pause_i),
        .o_qt   (w_div_qt)
    );

`ifdef GAME_TICK_SINGLE_STEP_EN
    // Single-step bypasses the divider, so its count is untouched.
    assign w_qt = w_div_qt || (pause_i && step_i);
`else
    assign w_qt = w_div_qt;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_pending <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_step_inc    = 1'b0;
        w_ovr_inc     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_qt || r_pending) begin
                    w_state_nxt   = ST_REQ;
                    w_pending_nxt = r_pending && w_qt;
                end
            end
            ST_REQ: begin
                if (step_ack_i) begin
                    w_state_nxt = ST_GAP;
                    w_step_inc  = 1'b1;
                end
                if (w_qt) begin
                    if (r_pending) w_ovr_inc     = 1'b1;
                    else           w_pending_nxt = 1'b1;
                end
            end
            ST_GAP: begin
                // Pending slot is consumed by the request that follows the gap.
                if (w_qt && r_pending) w_ovr_inc = 1'b1;
                if (w_qt || r_pending) begin
                    w_state_nxt   = ST_REQ;
                    w_pending_nxt = 1'b0;
                end else begin
                    w_state_nxt   = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_pending_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_req      <= 1'b0;
            r_busy     <= 1'b0;
            r_step_cnt <= '0;
            r_ovr_cnt  <= '0;
        end else begin
            r_req  <= (w_state_nxt == ST_REQ);
            r_busy <= busy_of(w_state_nxt, w_pending_nxt);
            if (w_step_inc) r_step_cnt <= r_step_cnt + CNT_W'(1);
            if (w_ovr_inc && (r_ovr_cnt != '1)) r_ovr_cnt <= r_ovr_cnt + OVR_W'(1);
        end
    end

    assign step_req_o    = r_req;
    assign busy_o        = r_busy;
    assign step_cnt_o    = r_step_cnt;
    assign overrun_cnt_o = r_ovr_cnt;

endmodule

// File: doc/game_tick_sched.md
Name: game_tick_sched

Overview:
- Consumes the 1-cycle game-tick pulse from the frame timer (one pulse every 5,000,000 clk cycles).
- Turns qualified ticks into a req/ack step handshake toward the game-logic update engine.
- Adds a tick divider, pause, a one-deep pending buffer, a frame counter and an overrun counter.
- Sits between the frame timer and the game-state update block.

Parameters:
- TICK_DIV, 1, ticks per game step (1..255); a step is qualified on every TICK_DIV-th unpaused tick.
- CNT_W, 16, width of step_cnt_o.
- OVR_W, 8, width of overrun_cnt_o.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset, asynchronous, active-low.
- tick_i  in  1  1-cycle tick pulse from the frame timer.
- pause_i  in  1  level; 1 = ignore ticks.
- step_req_o  out  1  step request to the game logic; held high until acknowledged.
- step_ack_i  in  1  game logic done; sampled only while step_req_o=1.
- busy_o  out  1  1 while step_req_o=1 or a step is pending.
- step_cnt_o  out  CNT_W  completed steps; wraps modulo 2^CNT_W.
- overrun_cnt_o  out  OVR_W  dropped qualified ticks; saturates at all-ones.

Behaviour:
- Reset (async, rstn=0): FSM=IDLE, divider=0, pending=0; step_req_o=0, busy_o=0, step_cnt_o=0, overrun_cnt_o=0. All outputs are registered.
- Divider:
  - On tick_i=1 with pause_i=0: if div==TICK_DIV-1, then div<=0 and a qualified tick "qt" is raised this cycle (combinational); else div<=div+1.
  - While pause_i=1 the divider holds and ticks are discarded. They do not count as overruns.
- FSM states: IDLE, REQ, GAP.
  - IDLE: qt or pending → REQ; step_req_o=1 from the next cycle; pending clears. Latency from tick_i to step_req_o = 1 cycle.
  - REQ: step_ack_i=1 → GAP; step_req_o=0 next cycle; step_cnt_o+1 on the same edge.
  - GAP: exactly 1 cycle with step_req_o=0 (guaranteed request separation). Then: pending=1 → REQ, else → IDLE.
- Pending buffer, for qt arriving in REQ or GAP (including the same cycle as step_ack_i):
  - pending=0: set pending=1.
  - pending=1: overrun_cnt_o+1, saturating.
- A qt in GAP with pending=0 sets pending; REQ follows GAP directly.
- Pause mid-operation: an outstanding REQ completes normally, and a set pending is still serviced. Pause blocks only new qualification.
- step_ack_i is ignored in IDLE and GAP.
- busy_o = (state!=IDLE) | pending, registered.

Optional Feature:
- Macro GAME_TICK_SINGLE_STEP_EN.
- Defined:
  - Adds port step_i (in, 1).
  - While pause_i=1, a step_i pulse acts as a qt, bypassing the divider (divider unchanged).
  - step_i is ignored while pause_i=0.
  - Same pending/overrun rules apply.
- Undefined: no step_i port; paused means no steps ever start.

Decomposition:
- Shared package game_pkg holds:
  - FSM state encoding constants ST_IDLE=2'd0, ST_REQ=2'd1, ST_GAP=2'd2.
  - Default widths.
  - Timer period constant TICK_PERIOD=5000000.
- One natural sub-module: tick_divider (divider counter plus qt generation, with hold on pause), reusable for other slower game rates.

Test Plan:
- Reset and basic step, TICK_DIV=1: pulse tick_i once; ack 10 cycles after req rises → req is high 1 cycle after tick, falls the cycle after ack; step_cnt_o=1, busy_o back to 0.
- Divider, TICK_DIV=3: 9 tick pulses, ack immediately each time → exactly 3 requests, on ticks 3, 6 and 9; step_cnt_o=3.
- Overrun: tick, then withhold ack while 3 more ticks arrive, then ack → pending serviced after the 1-cycle GAP as a second request; overrun_cnt_o=2; step_cnt_o=2 after the second ack.
- Saturation, OVR_W=2: hold the request while 6 extra ticks arrive → overrun_cnt_o sticks at 3.
- Pause: pause_i=1 during an outstanding request, plus 4 ticks → the request completes, no new request, overrun_cnt_o=0, divider unchanged. With GAME_TICK_SINGLE_STEP_EN, one step_i pulse → exactly one request.
- Async reset mid-REQ with pending=1 → all outputs 0 immediately, without waiting for a clock edge; the next tick starts a fresh request.
